// File: rtl/e_mdu_ctrl.sv
// Execute-stage multiply/divide unit for the pipelined MIPS core.
// Owns HI/LO, models multi-cycle MD latency with a busy counter, serves mfhi/mflo/mthi/mtlo.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] Y,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        phi, plo;
  logic               div_zero;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        abs_a, abs_b, safe_b, q_mag, r_mag;
  logic [31:0]        res_hi, res_lo;

  // Signed divide works on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    res_hi = 32'd0;
    res_lo = 32'd0;
    prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u = {32'd0, A} * {32'd0, B};
    abs_a  = A[31] ? -A : A;
    abs_b  = B[31] ? -B : B;
    safe_b = (B == 32'd0) ? 32'd1 : B;
    q_mag  = abs_a / ((abs_b == 32'd0) ? 32'd1 : abs_b);
    r_mag  = abs_a % ((abs_b == 32'd0) ? 32'd1 : abs_b);
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo = (A[31] ^ B[31]) ? -q_mag : q_mag;
        res_hi = A[31] ? -r_mag : r_mag;
      end
      OP_DIVU: begin
        res_lo = A / safe_b;
        res_hi = A % safe_b;
      end
      default: ;
    endcase
  end

  always_comb begin
    Y = 32'd0;
    if (op == OP_MFHI)      Y = HI;
    else if (op == OP_MFLO) Y = LO;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: pending results are reset too, so a reset mid-operation can never leak them into HI/LO.
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      HI       <= 32'd0;
      LO       <= 32'd0;
      phi      <= 32'd0;
      plo      <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                phi      <= res_hi;
                plo      <= res_lo;
                div_zero <= 1'b0;
                cnt      <= CNT_W'(MULT_CYCLES);
                busy     <= 1'b1;
                state    <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                phi      <= res_hi;
                plo      <= res_lo;
                div_zero <= (B == 32'd0);
                cnt      <= CNT_W'(DIV_CYCLES);
                busy     <= 1'b1;
                state    <= RUN;
              end
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is ignored here; the hazard unit stalls MD instructions while busy.
          if (cnt == CNT_W'(1)) begin
            if (!div_zero) begin
              HI <= phi;
              LO <= plo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Scoreboard bench for e_mdu_ctrl: stimulus queues expected commits, a monitor checks
// HI/LO hold while busy, commit values and busy length when busy falls.
module tb_e_mdu_ctrl;

  logic        clk, reset, start, busy;
  logic [3:0]  op;
  logic [31:0] A, B, Y, HI, LO;

  typedef struct {
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    logic [31:0] new_hi;
    logic [31:0] new_lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .Y(Y), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Launch an MD op (called just after a negedge); ends at the negedge after the launch edge.
  task automatic md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eh, input logic [31:0] el, input int cyc);
    sb.push_back('{model_hi, model_lo, eh, el, cyc});
    model_hi = eh;
    model_lo = el;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1 start = 1'b0; op = 4'd0;
    @(negedge clk);
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] a);
    start = 1'b1; op = o; A = a;
    @(posedge clk);
    #1 start = 1'b0; op = 4'd0;
    if (o == 4'd7) model_hi = a;
    else           model_lo = a;
    check("mt_hi", HI, model_hi);
    check("mt_lo", LO, model_lo);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: HI/LO must hold old values while busy; on busy fall, pop and compare.
  initial begin
    exp_t e;
    logic prev_busy;
    int   busy_len;
    prev_busy = 1'b0;
    busy_len  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        busy_len  = 0;
      end else if (busy) begin
        busy_len++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL busy_unexpected: busy=1 with no operation outstanding");
        end else begin
          check("hold_hi", HI, sb[0].old_hi);
          check("hold_lo", LO, sb[0].old_lo);
        end
        prev_busy = 1'b1;
      end else begin
        if (prev_busy) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL commit_unexpected: busy fell with no operation outstanding");
          end else begin
            e = sb.pop_front();
            check("commit_hi", HI, e.new_hi);
            check("commit_lo", LO, e.new_lo);
            check("busy_len", 32'(busy_len), 32'(e.cycles));
          end
        end
        prev_busy = 1'b0;
        busy_len  = 0;
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // signed mult -3 * 7
    md(4'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
    wait_idle();
    // multu, then back-to-back divu
    md(4'd2, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    wait_idle();
    md(4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10);
    wait_idle();
    // signed div -7 / 2, then overflow case
    md(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_idle();
    md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    wait_idle();

    // mthi/mtlo preload, then divide by zero leaves HI/LO
    mt(4'd7, 32'h11);
    mt(4'd8, 32'h22);
    md(4'd3, 32'h1234, 32'd0, 32'h11, 32'h22, 10);
    wait_idle();
    op = 4'd5;
    #1 check("mfhi_y", Y, 32'h11);
    start = 1'b1; op = 4'd6;
    #1 check("mflo_y", Y, 32'h22);
    @(posedge clk);
    #1 start = 1'b0; op = 4'd0;
    #1 check("none_y", Y, 32'd0);
    @(negedge clk);
    check("mflo_nochg_hi", HI, 32'h11);
    check("mflo_nochg_lo", LO, 32'h22);

    // starts during busy are ignored: 6 * -1
    md(4'd1, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    start = 1'b1; op = 4'd7; A = 32'hDEAD;
    @(posedge clk);
    #1 op = 4'd3; A = 32'd100; B = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; op = 4'd0;
    @(negedge clk);
    wait_idle();
    repeat (3) @(negedge clk);
    check("no_extra_busy", {31'd0, busy}, 32'd0);
    check("ignored_mthi", HI, 32'hFFFF_FFFF);

    // reset in busy cycle 4 of a divide discards the pending result
    md(4'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    sb.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);
    md(4'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5);
    wait_idle();

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Execute-stage multiply/divide unit with sequencing controller for the pipelined MIPS core; sits beside the E-stage ALU.
- Takes the same operand buses as the ALU and owns the architectural HI/LO registers.
- Models multi-cycle latency with a busy counter so the hazard unit can stall later MD instructions.
- Serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (≥1)
- DIV_CYCLES, 10, busy duration for div/divu (≥1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  valid MD instruction in E this cycle
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none
- A  input  32  rs operand
- B  input  32  rt operand
- busy  output  1  multi-cycle operation in progress
- Y  output  32  read data: HI when op=5, LO when op=6, else 0 (combinational)
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, busy=0, cnt=0, state IDLE, pending results discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Launch: in IDLE, at a clock edge with start=1 and op∈{1..4}:
  - Compute the result from A/B at that edge into internal pending registers phi/plo.
  - Load cnt with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4); go to RUN.
- Arithmetic:
  - mult: signed 32x32→64, {phi,plo}=product.
  - multu: same, unsigned.
  - div: plo=signed quotient truncated toward zero, phi=remainder with sign of A.
  - divu: unsigned quotient and remainder.
  - 0x80000000 / -1 (signed): quotient 0x80000000, remainder 0.
- Divide by zero (B=0, op 3/4): still RUN for DIV_CYCLES; HI/LO left unchanged at commit.
- RUN: cnt decrements each edge. On the edge where cnt==1: HI<=phi, LO<=plo, cnt<=0, go to IDLE. busy falls on that same edge.
- Latency: launch edge t0. busy=1 for exactly N cycles (after edges t0..t0+N-1). New HI/LO are visible after edge t0+N.
- While busy=1:
  - start with any op is ignored (no launch, no mthi/mtlo write). The hazard unit guarantees stall.
  - Y still reflects the current committed HI/LO.
- mthi/mtlo: in IDLE with start=1, at the edge, HI<=A (op 7) or LO<=A (op 8). Single-cycle; busy stays 0.
- mfhi/mflo: Y is combinational from committed HI/LO. Y does not depend on start. No state change.
- No back-to-back overlap: a launch can occur on the edge immediately after commit. busy is 0 in that cycle, so start is accepted.
- Ops 0 and 9–15 never change state.

Test Plan:
- reset; start, op=1, A=0xFFFFFFFD(-3), B=7 -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; HI/LO unchanged while busy.
- op=2, A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. Then op=4, A=7, B=2 -> busy 10 cycles; then LO=3, HI=1.
- op=3, A=0xFFFFFFF9(-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then op=3, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- HI=0x11, LO=0x22 preloaded via op=7/op=8 (busy never asserts); op=3, B=0 -> busy 10 cycles, HI=0x11, LO=0x22 after. op=5 -> Y=0x11; op=6 -> Y=0x22.
- during mult busy, assert start with op=7 A=0xDEAD, then op=3 -> both ignored; mult completes after original 5 cycles with correct product and no extra busy cycles.
- launch div, assert reset at busy cycle 4 -> immediately busy=0, HI=LO=0. After release, no commit occurs. A fresh op=1, A=3, B=4 yields LO=12 after 5 cycles.
